prco_fetch: RTL and testbench

- Instruction fetch stage of the PRCO core. Sits upstream of the decode stage and is the producing end of the decoder's valid/stall pipeline handshake.
- Issues word reads to instruction memory over a req/ack interface.
- Buffers returned instructions in a small FIFO tagged with their PC and presents the head to decode.
- Handles pipeline redirect (i_p_cp) with a new PC, discarding any in-flight or buffered fetches.

---
 rtl/prco_fetch_if.sv | 49 ++++
 rtl/prco_fetch.sv | 167 ++++++++++++++++
 tb/tb_prco_fetch.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/prco_fetch_if.sv
`default_nettype none
// ============================================================================
// Module      : prco_fetch_if
// Description : Bundles the PRCO fetch stage's memory request/ack bus and its
//               valid/stall handoff toward decode. The remaining control inputs
//               (enable, redirect) travel on the same bundle.
//               Modports:
//                 master - the fetch stage (drives q_* and samples i_*)
//                 slave  - memory/decode environment (drives i_*)
//               Signals:
//                 i_en          fetch enable
//                 i_p_cp        pipeline redirect/flush
//                 i_cp_target   redirect PC
//                 q_mem_req     registered memory read request
//                 q_mem_addr    registered word address
//                 i_mem_ack     read data valid (sampled only while q_mem_req)
//                 i_mem_data    instruction word
//                 q_p_valid     FIFO head valid
//                 i_p_stalled   decode stalled
//                 q_p_ce        handoff this cycle
//                 q_instr       FIFO head instruction
//                 q_pc          FIFO head PC
// Revision    : 1.0 - initial release
// ============================================================================
interface prco_fetch_if;
    logic        i_en;
    logic        i_p_cp;
    logic [15:0] i_cp_target;
    logic        q_mem_req;
    logic [15:0] q_mem_addr;
    logic        i_mem_ack;
    logic [15:0] i_mem_data;
    logic        q_p_valid;
    logic        i_p_stalled;
    logic        q_p_ce;
    logic [15:0] q_instr;
    logic [15:0] q_pc;

    modport master (
        input  i_en, i_p_cp, i_cp_target, i_mem_ack, i_mem_data, i_p_stalled,
        output q_mem_req, q_mem_addr, q_p_valid, q_p_ce, q_instr, q_pc
    );

    modport slave (
        output i_en, i_p_cp, i_cp_target, i_mem_ack, i_mem_data, i_p_stalled,
        input  q_mem_req, q_mem_addr, q_p_valid, q_p_ce, q_instr, q_pc
    );
endinterface
`default_nettype wire

// File: rtl/prco_fetch.sv
`default_nettype none
// ============================================================================
// Module      : prco_fetch
// Description : PRCO instruction fetch stage. Issues single outstanding word
//               reads, buffers returned words with their PC in a small FIFO
//               and presents the head to decode. A redirect (i_p_cp) flushes
//               the FIFO, reloads the fetch PC and drops any in-flight read.
// Ports       : i_clk    - clock, rising edge
//               i_reset  - synchronous active-high reset
//               bus      - prco_fetch_if.master (memory + decode handshake)
//               q_perf_fetched / q_perf_stall - only with PRCO_FETCH_PERF_EN
// Options     : `define PRCO_FETCH_PERF_EN adds saturating counters of pushed
//               instructions and of stalled-valid cycles.
// Parameters  : RESET_PC  - fetch PC after reset
//               BUF_DEPTH - FIFO depth, 2 or 4
// Revision    : 1.0 - initial release
// ============================================================================
module prco_fetch #(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter int          BUF_DEPTH = 2
) (
    input  wire logic         i_clk,
    input  wire logic         i_reset,
    prco_fetch_if.master      bus
`ifdef PRCO_FETCH_PERF_EN
    ,
    output logic [15:0]       q_perf_fetched,
    output logic [15:0]       q_perf_stall
`endif
);

    localparam int PTR_W = (BUF_DEPTH == 4) ? 2 : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] C_DEPTH = CNT_W'(BUF_DEPTH);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_WAIT    = 2'd1;
    localparam logic [1:0] ST_DISCARD = 2'd2;

    logic [1:0]       r_state;
    logic [15:0]      r_fetch_pc;
    logic             r_mem_req;
    logic [15:0]      r_mem_addr;
    logic [15:0]      r_instr_q [BUF_DEPTH];
    logic [15:0]      r_pc_q    [BUF_DEPTH];
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [CNT_W-1:0] r_count;

    logic w_ack;
    logic w_valid;
    logic w_pop;
    logic w_push;
    logic w_issue;

    // Ack is meaningless unless a request is actually on the bus.
    assign w_ack   = r_mem_req & bus.i_mem_ack;
    assign w_valid = (r_count != '0);
    assign w_pop   = w_valid & ~bus.i_p_stalled & ~bus.i_p_cp;
    // Only a WAIT-state ack carries live data; DISCARD acks are dropped.
    assign w_push  = (r_state == ST_WAIT) & w_ack & ~bus.i_p_cp;
    // Issuing only below full keeps the FIFO from overflowing, since at most
    // one read can be outstanding.
    assign w_issue = (r_state == ST_IDLE) & bus.i_en & ~bus.i_p_cp & (r_count < C_DEPTH);

    // ------------------------------------------------------------------------
    // FIFO and fetch PC
    // ------------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_fetch_pc <= RESET_PC;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
            for (int i = 0; i < BUF_DEPTH; i++) begin
                r_instr_q[i] <= 16'h0000;
                r_pc_q[i]    <= 16'h0000;
            end
        end else if (bus.i_p_cp) begin
            r_fetch_pc <= bus.i_cp_target;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
        end else begin
            if (w_push) begin
                r_instr_q[r_wr_ptr] <= bus.i_mem_data;
                r_pc_q[r_wr_ptr]    <= r_fetch_pc;
                r_wr_ptr            <= r_wr_ptr + PTR_W'(1);
                r_fetch_pc          <= r_fetch_pc + 16'h0001;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Request state machine
    // ------------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state    <= ST_IDLE;
            r_mem_req  <= 1'b0;
            r_mem_addr <= 16'h0000;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_issue) begin
                        r_mem_req  <= 1'b1;
                        r_mem_addr <= r_fetch_pc;
                        r_state    <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (w_ack) begin
                        r_mem_req <= 1'b0;
                        r_state   <= ST_IDLE;
                    end else if (bus.i_p_cp) begin
                        // Request stays on the bus; its data is now stale.
                        r_state <= ST_DISCARD;
                    end
                end
                ST_DISCARD: begin
                    if (w_ack) begin
                        r_mem_req <= 1'b0;
                        r_state   <= ST_IDLE;
                    end
                end
                default: begin
                    r_mem_req <= 1'b0;
                    r_state   <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.q_mem_req  = r_mem_req;
    assign bus.q_mem_addr = r_mem_addr;
    assign bus.q_p_valid  = w_valid;
    assign bus.q_p_ce     = w_pop;
    assign bus.q_instr    = r_instr_q[r_rd_ptr];
    assign bus.q_pc       = r_pc_q[r_rd_ptr];

`ifdef PRCO_FETCH_PERF_EN
    // Counters survive redirects; only reset clears them.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            q_perf_fetched <= 16'h0000;
            q_perf_stall   <= 16'h0000;
        end else begin
            if (w_push && (q_perf_fetched != 16'hFFFF)) begin
                q_perf_fetched <= q_perf_fetched + 16'h0001;
            end
            if (w_valid && bus.i_p_stalled && (q_perf_stall != 16'hFFFF)) begin
                q_perf_stall <= q_perf_stall + 16'h0001;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_prco_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_prco_fetch
// Description : Randomized self-checking bench for prco_fetch. Two instances
//               run under shared decode/redirect stimulus: one with defaults
//               (RESET_PC=0000, depth 2) and one with RESET_PC=FFFF, depth 4.
//               Each has its own memory responder (mem[a] = a ^ A500) and a
//               transaction-level reference model: number of buffered words,
//               next fetch PC, and whether a read is outstanding/stale.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_prco_fetch;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        en;
    logic        cp;
    logic [15:0] target;
    logic        stalled;
    logic        ack   [2];
    logic [15:0] mdata [2];

    logic        req_o   [2];
    logic [15:0] addr_o  [2];
    logic        valid_o [2];
    logic        ce_o    [2];
    logic [15:0] instr_o [2];
    logic [15:0] pc_o    [2];

    prco_fetch_if if0 ();
    prco_fetch_if if1 ();

    assign if0.i_en = en;          assign if1.i_en = en;
    assign if0.i_p_cp = cp;        assign if1.i_p_cp = cp;
    assign if0.i_cp_target = target; assign if1.i_cp_target = target;
    assign if0.i_p_stalled = stalled; assign if1.i_p_stalled = stalled;
    assign if0.i_mem_ack = ack[0]; assign if1.i_mem_ack = ack[1];
    assign if0.i_mem_data = mdata[0]; assign if1.i_mem_data = mdata[1];

    assign req_o[0] = if0.q_mem_req;   assign req_o[1] = if1.q_mem_req;
    assign addr_o[0] = if0.q_mem_addr; assign addr_o[1] = if1.q_mem_addr;
    assign valid_o[0] = if0.q_p_valid; assign valid_o[1] = if1.q_p_valid;
    assign ce_o[0] = if0.q_p_ce;       assign ce_o[1] = if1.q_p_ce;
    assign instr_o[0] = if0.q_instr;   assign instr_o[1] = if1.q_instr;
    assign pc_o[0] = if0.q_pc;         assign pc_o[1] = if1.q_pc;

`ifdef PRCO_FETCH_PERF_EN
    logic [15:0] perf_f [2];
    logic [15:0] perf_s [2];
`endif

    prco_fetch #(.RESET_PC(16'h0000), .BUF_DEPTH(2)) dut0 (
        .i_clk (clk),
        .i_reset (rst),
        .bus (if0)
`ifdef PRCO_FETCH_PERF_EN
        , .q_perf_fetched (perf_f[0]), .q_perf_stall (perf_s[0])
`endif
    );

    prco_fetch #(.RESET_PC(16'hFFFF), .BUF_DEPTH(4)) dut1 (
        .i_clk (clk),
        .i_reset (rst),
        .bus (if1)
`ifdef PRCO_FETCH_PERF_EN
        , .q_perf_fetched (perf_f[1]), .q_perf_stall (perf_s[1])
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] memf(input logic [15:0] a);
        return a ^ 16'hA500;
    endfunction

    function automatic logic [15:0] rst_pc_of(input int k);
        return (k == 0) ? 16'h0000 : 16'hFFFF;
    endfunction

    function automatic int depth_of(input int k);
        return (k == 0) ? 2 : 4;
    endfunction

    // Reference model state. The buffered words are always the m_count PCs
    // just below m_fetch_pc, so the head PC is m_fetch_pc - m_count.
    int          m_count   [2];
    logic [15:0] m_fetch_pc [2];
    bit          m_out     [2];
    bit          m_disc    [2];
    logic [15:0] m_addr    [2];
    int          m_perf_f  [2];
    int          m_perf_s  [2];

    // Memory responder state
    int r_wait  [2];
    int r_delay [2];

    task automatic model_reset(input int k);
        m_count[k]    = 0;
        m_fetch_pc[k] = rst_pc_of(k);
        m_out[k]      = 1'b0;
        m_disc[k]     = 1'b0;
        m_addr[k]     = 16'h0000;
        m_perf_f[k]   = 0;
        m_perf_s[k]   = 0;
    endtask

    task automatic model_step(input int k);
        bit          acc, push, pop, was_out;
        int          cnt_before;
        logic [15:0] fpc_before;
        acc        = m_out[k] && ack[k];
        push       = acc && !m_disc[k] && !cp;
        pop        = (m_count[k] > 0) && !stalled && !cp;
        was_out    = m_out[k];
        cnt_before = m_count[k];
        fpc_before = m_fetch_pc[k];
        if (push && m_perf_f[k] < 65535) m_perf_f[k]++;
        if (cnt_before > 0 && stalled && m_perf_s[k] < 65535) m_perf_s[k]++;
        if (cp) begin
            m_count[k]    = 0;
            m_fetch_pc[k] = target;
            if (was_out && !acc) m_disc[k] = 1'b1;
        end else begin
            m_count[k] = m_count[k] + (push ? 1 : 0) - (pop ? 1 : 0);
            if (push) m_fetch_pc[k] = m_fetch_pc[k] + 16'h0001;
        end
        if (acc) begin
            m_out[k]  = 1'b0;
            m_disc[k] = 1'b0;
        end
        if (!was_out && en && !cp && cnt_before < depth_of(k)) begin
            m_out[k]  = 1'b1;
            m_addr[k] = fpc_before;
        end
    endtask

    task automatic check_state(input int k, input int cyc, input bit after_reset);
        logic [15:0] head;
        head = m_fetch_pc[k] - 16'(m_count[k]);
        check_val($sformatf("d%0d c%0d req", k, cyc), 32'(req_o[k]), 32'(m_out[k]));
        if (m_out[k])
            check_val($sformatf("d%0d c%0d addr", k, cyc), 32'(addr_o[k]), 32'(m_addr[k]));
        check_val($sformatf("d%0d c%0d valid", k, cyc), 32'(valid_o[k]), 32'(m_count[k] > 0));
        if (m_count[k] > 0) begin
            check_val($sformatf("d%0d c%0d pc", k, cyc), 32'(pc_o[k]), 32'(head));
            check_val($sformatf("d%0d c%0d instr", k, cyc), 32'(instr_o[k]), 32'(memf(head)));
        end
        if (after_reset) begin
            check_val($sformatf("d%0d c%0d rst_addr", k, cyc), 32'(addr_o[k]), 32'h0);
            check_val($sformatf("d%0d c%0d rst_instr", k, cyc), 32'(instr_o[k]), 32'h0);
            check_val($sformatf("d%0d c%0d rst_pc", k, cyc), 32'(pc_o[k]), 32'h0);
        end
`ifdef PRCO_FETCH_PERF_EN
        check_val($sformatf("d%0d c%0d perf_f", k, cyc), 32'(perf_f[k]), 32'(m_perf_f[k]));
        check_val($sformatf("d%0d c%0d perf_s", k, cyc), 32'(perf_s[k]), 32'(m_perf_s[k]));
`endif
    endtask

    task automatic drive_mem(input int k);
        if (req_o[k]) begin
            ack[k]   = (r_wait[k] >= r_delay[k]);
            mdata[k] = ack[k] ? memf(addr_o[k]) : 16'($urandom);
            r_wait[k]++;
        end else begin
            // Stray acks with no request must be ignored by the DUT.
            ack[k]     = (($urandom % 8) == 0);
            mdata[k]   = 16'($urandom);
            r_wait[k]  = 0;
            r_delay[k] = $urandom_range(0, 3);
        end
    endtask

    initial begin
        bit do_rst;
        bit after_reset;
        en = 1'b0; cp = 1'b0; target = 16'h0000; stalled = 1'b0;
        for (int k = 0; k < 2; k++) begin
            ack[k] = 1'b0; mdata[k] = 16'h0000;
            r_wait[k] = 0; r_delay[k] = 0;
            model_reset(k);
        end
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        after_reset = 1'b1;

        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int k = 0; k < 2; k++) check_state(k, cyc, after_reset);
            after_reset = 1'b0;

            // Phases: clean streaming, heavy decode stall, then mixed traffic
            // with redirects (some near the FFFF wrap) and occasional resets.
            do_rst = 1'b0;
            cp     = 1'b0;
            target = 16'($urandom);
            if (cyc < 200) begin
                en = 1'b1; stalled = 1'b0;
            end else if (cyc < 400) begin
                en = 1'b1; stalled = (cyc < 260) ? 1'b1 : (($urandom % 4) != 0);
            end else begin
                en      = (($urandom % 8) != 0);
                stalled = (($urandom % 3) == 0);
                cp      = (($urandom % 16) == 0);
                if (($urandom % 3) == 0) target = 16'hFFFE + 16'($urandom_range(0, 1));
                do_rst  = (($urandom % 200) == 0);
            end
            rst = do_rst;
            for (int k = 0; k < 2; k++) drive_mem(k);

            #1;
            for (int k = 0; k < 2; k++)
                check_val($sformatf("d%0d c%0d ce", k, cyc), 32'(ce_o[k]),
                          32'((m_count[k] > 0) && !stalled && !cp));

            for (int k = 0; k < 2; k++) begin
                if (do_rst) model_reset(k);
                else        model_step(k);
            end
            after_reset = do_rst;

            @(posedge clk);
            #1;
            rst = 1'b0;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
